// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared constants, slot type and hex segment table for seg7_scan4.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

    typedef logic [$clog2(NUM_DIGITS)-1:0] slot_t;

    // Active-low, bit 6 = g down to bit 0 = a
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decode
// Brief    : Combinational hex nibble to active-low 7-segment pattern.
// Revision : 1.0
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan4.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan4
// Brief    : 4-digit multiplexed 7-segment scanner with per-scan shadowing
//            and end-of-slot anode blanking. Option: SEG7_LEADING_ZERO_BLANK_EN.
// Revision : 1.0
// ============================================================================
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           value,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  enable,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic [1:0]            digit
);

    // One extra bit so REFRESH_DIV itself fits when BLANK_CYCLES is zero
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_lit_end  = CNT_W'(REFRESH_DIV - BLANK_CYCLES);
    localparam slot_t            c_slot_last = slot_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      r_cnt;
    slot_t                 r_slot;
    logic [15:0]           r_shadow_val;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    slot_t                 r_digit;

    logic                  w_wrap;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg;
    logic                  w_lz_blank;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an;

    assign w_wrap   = (r_cnt == c_cnt_last);
    assign w_nibble = r_shadow_val[{r_slot, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_slot)
            2'd3:    w_lz_blank = (r_shadow_val[15:12] == 4'd0)  && !r_shadow_dp[3];
            2'd2:    w_lz_blank = (r_shadow_val[15:8]  == 8'd0)  && !r_shadow_dp[2];
            2'd1:    w_lz_blank = (r_shadow_val[15:4]  == 12'd0) && !r_shadow_dp[1];
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_lit = enable && (r_cnt < c_lit_end) && !w_lz_blank;
    assign w_an  = w_lit ? ~(NUM_DIGITS'(1) << r_slot) : AN_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_slot       <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_digit      <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_slot <= r_slot + 1'b1;
            end
            // Shadow only changes at the scan boundary so a scan never tears
            if (w_wrap && (r_slot == c_slot_last)) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_dp    <= ~r_shadow_dp[r_slot];
            r_digit <= r_slot;
        end
    end

    assign an    = r_an;
    assign seg7  = r_seg;
    assign dp    = r_dp;
    assign digit = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan4.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan4
// Brief    : Self-checking bench for seg7_scan4 (REFRESH_DIV=4, BLANK_CYCLES=1).
// Revision : 1.0
// ============================================================================
module tb_seg7_scan4;

    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg7;
    logic        dp;
    logic [1:0]  digit;

    seg7_scan4 #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .dp_in  (dp_in),
        .enable (enable),
        .an     (an),
        .seg7   (seg7),
        .dp     (dp),
        .digit  (digit)
    );

    always #5 clk = ~clk;

    logic [6:0] tb_hex [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        else
            passed++;
    endtask

    // Behavioural model: cycle k after reset release is slot (k/DIV)%4, phase k%DIV;
    // scan s displays the inputs seen on the last cycle of scan s-1.
    int          k_done  = 0;
    bit          started = 1'b0;
    logic [15:0] m_sv;
    logic [3:0]  m_sd;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [1:0]  e_dig;

    always begin
        @(posedge clk);
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_dig = 2'd0;
            m_sv = 16'h0; m_sd = 4'h0;
            k_done  = 0;
            started = 1'b1;
        end else if (started) begin
            int ph, sl;
            logic [15:0] upper;
            bit lit;
            ph    = k_done % DIV;
            sl    = (k_done / DIV) % 4;
            upper = m_sv >> (4 * sl);
            lit   = enable && (ph < DIV - BLANK);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (sl != 0 && upper == 16'h0 && !m_sd[sl]) lit = 1'b0;
`endif
            e_an  = lit ? ~(4'b0001 << sl) : 4'hF;
            e_seg = tb_hex[upper[3:0]];
            e_dp  = ~m_sd[sl];
            e_dig = 2'(sl);
            if (ph == DIV - 1 && sl == 3) begin
                m_sv = value;
                m_sd = dp_in;
            end
            k_done++;
        end
        #1;
        if (started) begin
            chk("model an",    {12'h0, an},    {12'h0, e_an});
            chk("model seg7",  {9'h0, seg7},   {9'h0, e_seg});
            chk("model dp",    {15'h0, dp},    {15'h0, e_dp});
            chk("model digit", {14'h0, digit}, {14'h0, e_dig});
        end
    end

    // Wait until the outputs visible at a negedge reflect cycle t
    task automatic wait_to(input int t);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (k_done - 1 == t) return;
        end
        chk("wait_to timeout", 16'(k_done - 1), 16'(t));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; value = 16'h0; dp_in = 4'h0; enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset an",    {12'h0, an},    16'hF);
        chk("reset seg7",  {9'h0, seg7},   16'h7F);
        chk("reset dp",    {15'h0, dp},    16'h1);
        chk("reset digit", {14'h0, digit}, 16'h0);
        rst = 1'b0;

        wait_to(0);
        chk("first slot an",   {12'h0, an},   16'hE);
        chk("first slot seg7", {9'h0, seg7},  16'h40);
        wait_to(3);
        chk("first slot blank", {12'h0, an},  16'hF);
        value = 16'h1234;

        wait_to(16); chk("1234 d0 seg", {9'h0, seg7}, 16'h19); chk("1234 d0 an", {12'h0, an}, 16'hE);
        wait_to(20); chk("1234 d1 seg", {9'h0, seg7}, 16'h30); chk("1234 d1 an", {12'h0, an}, 16'hD);
        wait_to(21); value = 16'hFFFF;
        wait_to(24); chk("tear d2 seg", {9'h0, seg7}, 16'h24); chk("tear d2 an", {12'h0, an}, 16'hB);
        wait_to(28); chk("tear d3 seg", {9'h0, seg7}, 16'h79); chk("tear d3 an", {12'h0, an}, 16'h7);
        wait_to(32); chk("FFFF d0 seg", {9'h0, seg7}, 16'h0E); chk("FFFF d0 an", {12'h0, an}, 16'hE);

        wait_to(45); enable = 1'b0;
        wait_to(50); chk("disabled an", {12'h0, an}, 16'hF); chk("disabled digit", {14'h0, digit}, 16'h0);
        wait_to(55); enable = 1'b1;
        wait_to(56); chk("resume an", {12'h0, an}, 16'hB);

        wait_to(57); value = 16'h0005;
        wait_to(64); chk("lz d0 seg", {9'h0, seg7}, 16'h12); chk("lz d0 an", {12'h0, an}, 16'hE);
        wait_to(68);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("lz d1 an", {12'h0, an}, 16'hF);
`else
        chk("lz d1 an", {12'h0, an}, 16'hD);
`endif
        chk("lz d1 seg", {9'h0, seg7}, 16'h40);

        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            value  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            dp_in  = 4'($urandom);
            if ($urandom_range(0, 1) == 0) dp_in = 4'h0;
            enable = ($urandom_range(0, 7) != 0);
        end

        value = 16'hABCD; dp_in = 4'hF; enable = 1'b1;
        t = k_done + 2;
        while (t % 16 != 9) t++;
        wait_to(t - 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset an",    {12'h0, an},    16'hF);
        chk("midreset seg7",  {9'h0, seg7},   16'h7F);
        chk("midreset dp",    {15'h0, dp},    16'h1);
        chk("midreset digit", {14'h0, digit}, 16'h0);
        rst = 1'b0;
        wait_to(0);  chk("post reset d0 seg", {9'h0, seg7}, 16'h40);
        wait_to(4);  chk("post reset d1 seg", {9'h0, seg7}, 16'h40); chk("post reset d1 an", {12'h0, an}, 16'hD);
        wait_to(16); chk("ABCD d0 seg", {9'h0, seg7}, 16'h21); chk("ABCD d0 dp", {15'h0, dp}, 16'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
